div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//   Multi-cycle unsigned radix-2 restoring divider. Responder side of the execute-stage
//   valid/done divide handshake. Execute holds valid with magnitudes a,b and stalls while
//   valid & ~done; this block returns c = {remainder, quotient} (hi, lo).
//   Execute applies the sign fix-up for DIV; this block is purely unsigned.
// PARAMETERS
//   WIDTH    32             operand width; c is 2*WIDTH
//   CNT_W    $clog2(WIDTH)+1 iteration counter width (derived, not overridden)
// PORTS
//   clk      in   1        clock, rising edge
//   resetn   in   1        asynchronous active-low reset
//   valid    in   1        divide requested; level, held by initiator until done
//   a        in   WIDTH    dividend (unsigned)
//   b        in   WIDTH    divisor (unsigned)
//   done     out  1        result valid this cycle (single-cycle pulse)
//   c        out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, done=0, c=0, counter=0, internal regs=0.
// - States: IDLE, BUSY, DONE.
//   IDLE: valid=1 -> latch a,b; rem=0, quo=a, cnt=WIDTH; -> BUSY. valid=0 -> stay.
//   BUSY: per cycle {rem,quo} <<= 1; if rem_shifted >= b: rem -= b, quo[0]=1. cnt--.
//         cnt reaches 0 after this step -> DONE. valid=0 in BUSY -> abort, -> IDLE,
//         done stays 0, c unchanged (flush/exception path).
//   DONE: done=1 for exactly this cycle, c={rem,quo} (registered, updated on DONE entry);
//         -> IDLE unconditionally.
// - Latency: accept at edge 0 -> done high in cycle WIDTH+1 (33 for WIDTH=32).
// - c holds last result until next DONE; never changes on abort or in IDLE.
// - Operands sampled only at IDLE->BUSY; a,b changes during BUSY ignored.
// - Divide by zero: no special path; algorithm yields quotient=all-ones,
//   remainder=a. Execute does not trap.
// - valid still high in the IDLE cycle after DONE (E frozen by another stall):
//   restarts with current operands; same result recomputed. Correct, only slower.
// - Compare is WIDTH+1 bits (shifted rem carries out bit WIDTH) so b >= 2^(WIDTH-1)
//   divides correctly.
// - No combinational path valid/a/b -> done/c; all outputs registered.
// STRUCTURE
//   Shared package: div_state_t enum {IDLE,BUSY,DONE}; DIV_WIDTH=32.
//   Operand/result types reuse the pipeline i32/i64 typedefs.
//   One natural sub-module: div_step (combinational: rem,quo,b -> rem',quo', one
//   restoring iteration), instanced once in BUSY datapath; FSM and counter stay top-level.
// TESTING
// 1. a=100,b=7 valid held -> done pulse exactly cycle 33 after accept,
//    c={32'd2,32'd14}; done=0 in cycle 34.
// 2. a=5,b=0 -> c={32'd5,32'hFFFF_FFFF}; a=32'hFFFF_FFFF,b=1 -> c={0,32'hFFFF_FFFF}.
// 3. a=32'hFFFF_FFFF,b=32'h8000_0001 -> c={32'h7FFF_FFFE,32'd1} (carry-out compare path).
// 4. Accept a=50,b=3, drop valid at cycle 10 -> no done, IDLE next cycle, c unchanged;
//    then a=9,b=4 -> c={1,2} after 33 cycles.
// 5. resetn low at cycle 15 of an op -> done=0,c=0 immediately (async); after release,
//    new op a=1,b=1 -> c={0,1}.
// 6. Back-to-back: valid held across DONE with new a=7,b=2 next cycle -> second done
//    33 cycles after restart, c={1,3}; random unsigned pairs vs a/b, a%b reference.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider.
// State encoding and operand widths.
package div_iter_pkg;
  localparam int DIV_WIDTH = 32;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration.
// Purely combinational shift/compare/subtract.
module div_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] rem_sh;

  // Shifted remainder carries out bit WIDTH, so compare on WIDTH+1 bits.
  assign rem_sh = {rem, quo[WIDTH-1]};

  always_comb begin
    rem_n = rem_sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, b}) begin
      rem_n    = rem_sh[WIDTH-1:0] - b;
      quo_n[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle unsigned restoring divider.
// Returns c = {remainder, quotient} with a one-cycle done pulse.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  div_state_t       state_n;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] bq;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [2*WIDTH-1:0] c_q;
  logic             last;

  assign last = (cnt == CNT_W'(1));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem  (rem),
    .quo  (quo),
    .b    (bq),
    .rem_n(rem_n),
    .quo_n(quo_n)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (valid) state_n = BUSY;
      BUSY: begin
        if (!valid)
          state_n = IDLE;
        else if (last)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rem   <= '0;
      quo   <= '0;
      bq    <= '0;
      cnt   <= '0;
      c_q   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (valid) begin
            rem <= '0;
            quo <= a;
            bq  <= b;
            cnt <= CNT_W'(WIDTH);
          end
        end
        BUSY: begin
          // Dropping valid mid-op aborts without touching c.
          if (valid) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt - CNT_W'(1);
            if (last)
              c_q <= {rem_n, quo_n};
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);
  assign c    = c_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and random checks for div_iter.
// Latency, corner operands, abort, async reset, back-to-back.
module tb_div_iter;
  import div_iter_pkg::*;

  typedef struct {
    i32    a;
    i32    b;
    i32    q;
    i32    r;
    string nm;
  } vec_t;

  logic clk;
  logic resetn;
  logic valid;
  i32   a;
  i32   b;
  logic done;
  i64   c;

  int n_vec;
  int n_err;

  vec_t tbl[$];

  div_iter dut (
    .clk   (clk),
    .resetn(resetn),
    .valid (valid),
    .a     (a),
    .b     (b),
    .done  (done),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input i64 got, input i64 exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic run_op(input i32 ta, input i32 tb_,
                        input int lat, input string nm,
                        output i64 res);
    int n;
    bit seen;
    a     = ta;
    b     = tb_;
    valid = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk({nm, " latency"}, seen ? i64'(n) : '1, i64'(lat));
    res = c;
  endtask

  task automatic end_op(input string nm);
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " done pulse"}, i64'(done), 64'd0);
  endtask

  task automatic add(input i32 ta, input i32 tb_,
                     input i32 q, input i32 r,
                     input string nm);
    vec_t v;
    v.a  = ta;
    v.b  = tb_;
    v.q  = q;
    v.r  = r;
    v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    i64 res;
    i64 prev;
    i32 ra;
    i32 rb;
    int hits;

    n_vec = 0;
    n_err = 0;

    add(32'd100, 32'd7, 32'd14, 32'd2, "100/7");
    add(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "5/0");
    add(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "max/1");
    add(32'hFFFF_FFFF, 32'h8000_0001, 32'd1,
        32'h7FFF_FFFE, "max/8000_0001");
    add(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, "msb/msb");
    add(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,
        32'h7FFF_FFFF, "small/big");
    add(32'd0, 32'd5, 32'd0, 32'd0, "0/5");
    add(32'd12345678, 32'd1000, 32'd12345, 32'd678, "12345678/1000");
    add(32'd1000, 32'd10, 32'd100, 32'd0, "1000/10");

    valid  = 1'b0;
    a      = '0;
    b      = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", i64'(done), 64'd0);
    chk("reset c", c, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, 33, tbl[i].nm, res);
      chk(tbl[i].nm, res, {tbl[i].r, tbl[i].q});
      end_op(tbl[i].nm);
    end

    prev  = c;
    a     = 32'd50;
    b     = 32'd3;
    valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    valid = 1'b0;
    a     = 32'd77;
    hits  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) hits++;
    end
    chk("abort done", i64'(hits), 64'd0);
    chk("abort c", c, prev);
    run_op(32'd9, 32'd4, 33, "9/4", res);
    chk("9/4 after abort", res, {32'd1, 32'd2});
    end_op("9/4");

    a     = 32'd50;
    b     = 32'd3;
    valid = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async reset done", i64'(done), 64'd0);
    chk("async reset c", c, 64'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd1, 32'd1, 33, "1/1", res);
    chk("1/1 after reset", res, {32'd0, 32'd1});
    end_op("1/1");

    run_op(32'd20, 32'd6, 33, "20/6", res);
    chk("20/6", res, {32'd2, 32'd3});
    run_op(32'd7, 32'd2, 34, "b2b 7/2", res);
    chk("b2b 7/2", res, {32'd1, 32'd3});
    end_op("b2b 7/2");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      if (i % 2 == 0) rb = $urandom;
      else rb = $urandom_range(1, 1000);
      if (rb == 0) rb = 32'd1;
      run_op(ra, rb, 33, "rand", res);
      chk($sformatf("rand %h/%h", ra, rb), res, {ra % rb, ra / rb});
      end_op("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
